// File: rtl/led_sequencer.sv
// led_sequencer: multi-channel LED pattern generator.
// A prescaler divides clk down to one step every STEP_CYCLES enabled cycles;
// each step advances a position that is decoded into one of four patterns.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         1 = run, 0 = pause (prescaler, position and direction hold)
//   mode       pattern select: 0 CHASE, 1 BAR, 2 BOUNCE, 3 DRAIN
//   led        registered pattern, 1 = LED on
//   step_pulse registered, one cycle on every position advance
//   wrap       registered, one cycle when an advance lands on position 0
module led_sequencer #(
  parameter int unsigned N_LED       = 4,
  parameter int unsigned STEP_CYCLES = 12_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             step_pulse,
  output logic             wrap
);

  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned PW = (N_LED > 1) ? $clog2(N_LED) : 1;

  localparam logic [CW-1:0] CNT_LAST      = CW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] POS_TOP       = PW'(N_LED - 1);
  localparam logic [PW-1:0] POS_BELOW_TOP = PW'((N_LED > 1) ? (N_LED - 2) : 0);

  localparam logic [1:0] MODE_CHASE  = 2'd0;
  localparam logic [1:0] MODE_BAR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_DRAIN  = 2'd3;

  // Architectural state
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          up_q, up_d;
  logic [1:0]    mode_q, mode_d;
  // Set by reset so the first released edge restarts the sequence exactly
  // like a mode change; this makes the first step land STEP_CYCLES edges
  // after release regardless of the mode selected at that time.
  logic          start_q, start_d;

  logic [N_LED-1:0] led_d;
  logic             step_d;
  logic             wrap_d;
  logic             restart;

  // Pattern decode of a position for a given mode
  function automatic logic [N_LED-1:0] decode(input logic [PW-1:0] p,
                                              input logic [1:0]    m);
    logic [N_LED-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      case (m)
        MODE_BAR:   v[i] = (i <= int'(p));
        MODE_DRAIN: v[i] = (i >= int'(p));
        MODE_CHASE,
        MODE_BOUNCE: v[i] = (i == int'(p));
        default:    v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  // Next-state and output logic
  always_comb begin
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    up_d    = up_q;
    mode_d  = mode_q;
    start_d = 1'b0;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    restart = start_q || (mode != mode_q);

    if (restart) begin
      // Mode change wins over a coincident step and emits no pulses
      cnt_d  = '0;
      pos_d  = '0;
      up_d   = 1'b1;
      mode_d = mode;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        step_d = 1'b1;
        if (N_LED == 1) begin
          pos_d = '0;
        end else if (mode_q == MODE_BOUNCE) begin
          if (up_q) begin
            if (pos_q == POS_TOP) begin
              pos_d = POS_BELOW_TOP;
              up_d  = 1'b0;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = PW'(1);
              up_d  = 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end else begin
          pos_d = (pos_q == POS_TOP) ? '0 : (pos_q + 1'b1);
        end
        wrap_d = (pos_d == '0);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // LEDs follow the next-state position and the live mode input
    led_d = decode(pos_d, mode);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pos_q      <= '0;
      up_q       <= 1'b1;
      mode_q     <= MODE_CHASE;
      start_q    <= 1'b1;
      led        <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      up_q       <= up_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      led        <= led_d;
      step_pulse <= step_d;
      wrap       <= wrap_d;
    end
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised multi-channel LED pattern generator for STEPFPGA boards. It is driven by the on-board clock and advances a position counter once per programmable step period. The position is decoded into one of four display patterns on `N_LED` outputs. It adds run/pause, runtime mode selection, bounce sequencing and step/wrap status pulses for use by other blocks.

## Interface
- `N_LED`, default 4: number of LED channels; legal range 1..32.
- `STEP_CYCLES`, default 12_000_000: clock cycles per step (1 s at 12 MHz); legal range ≥1.
- `clk`  in  1  system clock (PCLK, 12 MHz).
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `en`  in  1  1 = run, 0 = pause (prescaler and position hold).
- `mode`  in  2  pattern select: 0 CHASE, 1 BAR, 2 BOUNCE, 3 DRAIN.
- `led`  out  N_LED  registered pattern output, 1 = LED on.
- `step_pulse`  out  1  registered, high for 1 cycle on each position advance.
- `wrap`  out  1  registered, high for 1 cycle when a position advance lands on pos 0.

## Operation
- Internal state:
  - prescaler `cnt`: width max(1, clog2(STEP_CYCLES)), range 0..STEP_CYCLES-1.
  - position `pos`: range 0..N_LED-1.
  - bounce direction `up`: 1 = incrementing.
  - registered copy `mode_q`.
- Step event: `en`=1 and `cnt`==STEP_CYCLES-1, with no mode change pending.
  - On a step event, `cnt`←0 and `pos` advances.
  - Otherwise, if `en`=1, `cnt`←`cnt`+1.
  - If `en`=0, `cnt`, `pos` and `up` hold.
- STEP_CYCLES=1: every enabled cycle is a step event.
- Advance rules:
  - CHASE, BAR, DRAIN: `pos`←`pos`+1, wrapping N_LED-1→0.
  - BOUNCE, `up`=1: `pos`+1; at N_LED-1 it clears `up` and goes to N_LED-2.
  - BOUNCE, `up`=0: `pos`-1; at 0 it sets `up` and goes to 1.
  - N_LED=1: `pos` stays 0 in all modes, and every step asserts `wrap`.
- Decode of `led[i]` from (`pos`, `mode`):
  - CHASE: `led[i]` = (i==pos).
  - BAR: `led[i]` = (i≤pos).
  - BOUNCE: `led[i]` = (i==pos).
  - DRAIN: `led[i]` = (i≥pos). All LEDs are on at pos 0; they turn off in ascending order.
- `led` is loaded every cycle with the decode of the next-state `pos` and current `mode`. It therefore tracks `mode` even while paused.
- Mode change (`mode`≠`mode_q`):
  - Takes priority over a step event in the same cycle.
  - `pos`←0, `cnt`←0, `up`←1, `mode_q`←`mode`.
  - `led`←decode(0, new mode).
  - `step_pulse`=0 and `wrap`=0.
- `wrap` is asserted together with `step_pulse` whenever the new `pos` is 0. In BOUNCE this means on return 1→0, which completes a full round trip.

## Timing
- Reset (`rst`=1 at a rising edge) drives:
  - `cnt`=0, `pos`=0, `up`=1, `mode_q`=0.
  - `led`=0 (all off), `step_pulse`=0, `wrap`=0.
- Reset mid-operation aborts the sequence on the next edge; it has priority over `en` and mode change.
- First edge with `rst`=0: `led`←decode(0, `mode`). If `mode`≠0, this is handled as a mode change.
- With `en` held at 1 from reset release, the first step occurs STEP_CYCLES edges after the first edge with `rst`=0.
- On the step edge, `pos`, `led`, `step_pulse` and `wrap` all update together: zero added latency between `pos` and outputs.
- Step period is exactly STEP_CYCLES enabled cycles. Pausing stretches the step by the number of paused cycles and loses no counts.
- `en` falling in the cycle where `cnt`==STEP_CYCLES-1 suppresses that step; the step fires on the first enabled cycle after `en` returns.
- `step_pulse` and `wrap` never exceed 1 cycle wide, except STEP_CYCLES=1 with `en` held high, where `step_pulse` is continuous.

## Test plan
- Parameters N_LED=4, STEP_CYCLES=4, `mode`=0, `en`=1 after reset:
  - `led` = 0001 on the first post-reset edge, then 0010, 0100, 1000, 0001 at 4-cycle intervals.
  - `wrap` high only with the 1000→0001 step; `step_pulse` high every 4th cycle.
- `mode`=3 (DRAIN), `en`=1: `led` sequence 1111, 1110, 1100, 1000, 1111. `wrap` accompanies the return to 1111.
- `mode`=2 (BOUNCE): `pos` sequence 0,1,2,3,2,1,0,1. `wrap` asserted only at the 1→0 step.
  - Repeat with N_LED=2: sequence 0,1,0,1.
  - Repeat with N_LED=1: `led`=1 constant, `wrap` every step.
- Pause: `mode`=1, run to `pos`=2 (`led`=0111), then drop `en` for 10 cycles when `cnt`=3.
  - `led` stays 0111 throughout the pause, with no pulses.
  - The step to 1111 occurs on the first cycle after `en`=1.
- Mode change coincident with a step event (`cnt`=3, `en`=1, `mode` 0→1 at `pos`=2):
  - Next `led`=0001, `pos`=0, no `step_pulse`.
  - Next step follows 4 enabled cycles later.
- Reset mid-sequence at `pos`=3, plus a STEP_CYCLES=1 build:
  - Reset: `led`=0, pulses 0 on the reset edge; the sequence restarts at `pos` 0.
  - STEP_CYCLES=1: `pos` advances every cycle and `step_pulse` stays high while `en`=1.
